// File: rtl/vga_rx_monitor_if.sv
// rtl/vga_rx_monitor_if.sv - VGA pixel stream bundle seen by the receive-side monitor
interface vga_rx_monitor_if;
    logic       vga_clk;
    logic       hsync;
    logic       vsync;
    logic       vga_blank_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    modport master (
        output vga_clk, hsync, vsync, vga_blank_n, r, g, b
    );

    modport slave (
        input  vga_clk, hsync, vsync, vga_blank_n, r, g, b
    );
endinterface

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA sink: recovers line/frame timing, lock, frame checksum and pixel probe
module vga_rx_monitor #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic               clk,
    input  logic               rst,
    vga_rx_monitor_if.slave    vga,
    input  logic [9:0]         probe_x,
    input  logic [9:0]         probe_y,
    output logic               locked,
    output logic               err,
    output logic [9:0]         line_len,
    output logic [9:0]         frame_lines,
    output logic [15:0]        frame_sum,
    output logic [23:0]        probe_rgb,
    output logic               frame_done
);

    typedef enum logic [1:0] {SEARCH, ARM, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        vclk_q, vclk_d;
    logic        hs_q, hs_d, vs_q, vs_d, bl_q, bl_d;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0]  xcnt_q, xcnt_d, ycnt_q, ycnt_d;
    logic        line_act_q, line_act_d;
    logic        line_ok_q, line_ok_d;
    logic [15:0] acc_q, acc_d;
    logic [9:0]  line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic [15:0] frame_sum_q, frame_sum_d;
    logic [23:0] probe_rgb_q, probe_rgb_d;
    logic        err_q, err_d, frame_done_q, frame_done_d;

    logic        tick, h_fall, v_fall, len_good, ok_eff;
    logic [10:0] meas;
    logic [9:0]  vcnt_new, x_cur, y_line;
    logic [15:0] acc_sum;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        vclk_d        = vga.vga_clk;
        hs_d          = hs_q;
        vs_d          = vs_q;
        bl_d          = bl_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        xcnt_d        = xcnt_q;
        ycnt_d        = ycnt_q;
        line_act_d    = line_act_q;
        line_ok_d     = line_ok_q;
        acc_d         = acc_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        frame_sum_d   = frame_sum_q;
        probe_rgb_d   = probe_rgb_q;
        err_d         = err_q;
        frame_done_d  = 1'b0;
        ok_eff        = line_ok_q;

        tick     = vga.vga_clk & ~vclk_q;
        h_fall   = tick & hs_q & ~vga.hsync;
        v_fall   = tick & vs_q & ~vga.vsync;
        meas     = {1'b0, hcnt_q} + 11'd1;
        len_good = (meas == 11'(H_TOTAL));
        vcnt_new = h_fall ? sat_inc(vcnt_q) : vcnt_q;
        x_cur    = bl_q ? xcnt_q : 10'd0;
        // A closing line is counted into y before a same-tick frame close resets it
        y_line   = (h_fall && line_act_q) ? sat_inc(ycnt_q) : ycnt_q;
        if (v_fall) y_line = 10'd0;
        acc_sum  = acc_q + (vga.vga_blank_n ? {8'd0, vga.r ^ vga.g ^ vga.b} : 16'd0);

        if (tick) begin
            hs_d   = vga.hsync;
            vs_d   = vga.vsync;
            bl_d   = vga.vga_blank_n;
            hcnt_d = h_fall ? 10'd0 : sat_inc(hcnt_q);
            vcnt_d = vcnt_new;
            ycnt_d = y_line;
            acc_d  = acc_sum;
            line_act_d = h_fall ? vga.vga_blank_n : (line_act_q | vga.vga_blank_n);

            if (h_fall) line_len_d = meas[10] ? 10'h3FF : meas[9:0];

            if (vga.vga_blank_n) begin
                xcnt_d = sat_inc(x_cur);
                if (x_cur == probe_x && y_line == probe_y)
                    probe_rgb_d = {vga.r, vga.g, vga.b};
            end

            if (v_fall) begin
                frame_lines_d = vcnt_new;
                vcnt_d        = 10'd0;
                frame_sum_d   = acc_sum;
                acc_d         = 16'd0;
                frame_done_d  = 1'b1;
            end

            case (state_q)
                SEARCH: begin
                    if (v_fall) begin
                        state_d   = ARM;
                        line_ok_d = 1'b1;
                    end
                end
                ARM: begin
                    ok_eff    = line_ok_q & ~(h_fall & ~len_good);
                    line_ok_d = ok_eff;
                    if (v_fall) begin
                        if (ok_eff && vcnt_new == 10'(V_TOTAL)) state_d = LOCKED;
                        line_ok_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if ((h_fall && !len_good) || (v_fall && vcnt_new != 10'(V_TOTAL))) begin
                        state_d = SEARCH;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= SEARCH;
            vclk_q        <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            bl_q          <= 1'b0;
            hcnt_q        <= 10'd0;
            vcnt_q        <= 10'd0;
            xcnt_q        <= 10'd0;
            ycnt_q        <= 10'd0;
            line_act_q    <= 1'b0;
            line_ok_q     <= 1'b0;
            acc_q         <= 16'd0;
            line_len_q    <= 10'd0;
            frame_lines_q <= 10'd0;
            frame_sum_q   <= 16'd0;
            probe_rgb_q   <= 24'd0;
            err_q         <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            vclk_q        <= vclk_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            bl_q          <= bl_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            xcnt_q        <= xcnt_d;
            ycnt_q        <= ycnt_d;
            line_act_q    <= line_act_d;
            line_ok_q     <= line_ok_d;
            acc_q         <= acc_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            frame_sum_q   <= frame_sum_d;
            probe_rgb_q   <= probe_rgb_d;
            err_q         <= err_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign err         = err_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign frame_sum   = frame_sum_q;
    assign probe_rgb   = probe_rgb_q;
    assign frame_done  = frame_done_q;

endmodule
